// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: hex font, register map, CTRL fields, FSM states.
package seg7_pkg;

  // Active-low {g,f,e,d,c,b,a} patterns for the hex digits 0..F.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [1:0] ADDR_VALUE = 2'd0;
  localparam logic [1:0] ADDR_CTRL  = 2'd1;

  localparam int CTRL_W  = 6;
  localparam int CTRL_LZ = 4;
  localparam int CTRL_EN = 5;

  localparam logic [CTRL_W-1:0] CTRL_RST = 6'h20;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

endpackage

// File: rtl/hex7seg.sv
// Nibble to active-low seven-segment decoder; purely combinational.
module hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_FONT[i_nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment controller with shadow registers committed at frame start.
// Display outputs are registered one cycle behind the scan FSM; writes are always accepted.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic [3:0]  disp_sel,
  output logic [7:0]  disp_dig
);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  logic [15:0]       r_shadow_val;
  logic [CTRL_W-1:0] r_shadow_ctrl;
  logic [15:0]       r_active_val;
  logic [CTRL_W-1:0] r_active_ctrl;
  logic              r_pending;

  state_e            r_state;
  logic [1:0]        r_digit;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_disp_sel;
  logic [7:0]        r_disp_dig;

  logic              w_wr_val;
  logic              w_wr_ctrl;
  logic              w_show_done;
  logic              w_blank_done;
  logic              w_adv;
  logic              w_commit;
  logic [3:0]        w_nib;
  logic [6:0]        w_seg;
  logic              w_lz_dark;
  logic [3:0]        w_sel_nxt;
  logic [7:0]        w_dig_nxt;

  assign w_wr_val  = we && (addr == ADDR_VALUE);
  assign w_wr_ctrl = we && (addr == ADDR_CTRL);

  assign w_show_done  = (r_state == ST_SHOW)  && (r_cnt == SHOW_LAST);
  assign w_blank_done = (r_state == ST_BLANK) && (r_cnt == BLANK_LAST);
  assign w_adv        = (w_show_done && (BLANK_CYCLES == 0)) || w_blank_done;
  // Advancing out of digit 3 is the entry into SHOW(0): the only point where the active copy may change.
  assign w_commit     = w_adv && (r_digit == 2'd3) && r_pending;

  always_comb begin
    case (addr)
      ADDR_VALUE: rdata = r_shadow_val;
      ADDR_CTRL:  rdata = {{(16-CTRL_W){1'b0}}, r_shadow_ctrl};
      default:    rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow_val  <= 16'h0000;
      r_shadow_ctrl <= CTRL_RST;
      r_active_val  <= 16'h0000;
      r_active_ctrl <= CTRL_RST;
      r_pending     <= 1'b0;
    end else begin
      if (w_wr_val)  r_shadow_val  <= wdata;
      if (w_wr_ctrl) r_shadow_ctrl <= wdata[CTRL_W-1:0];
      if (w_commit) begin
        r_active_val  <= r_shadow_val;
        r_active_ctrl <= r_shadow_ctrl;
      end
      if (w_wr_val || w_wr_ctrl) r_pending <= 1'b1;
      else if (w_commit)         r_pending <= 1'b0;
    end
  end

  assign w_nib = r_active_val[{r_digit, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_comb begin
    w_lz_dark = 1'b0;
    if (r_active_ctrl[CTRL_LZ]) begin
      case (r_digit)
        2'd1:    w_lz_dark = ~|r_active_val[15:4];
        2'd2:    w_lz_dark = ~|r_active_val[15:8];
        2'd3:    w_lz_dark = ~|r_active_val[15:12];
        default: w_lz_dark = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_sel_nxt = 4'hF;
    w_dig_nxt = 8'hFF;
    if ((r_state == ST_SHOW) && r_active_ctrl[CTRL_EN]) begin
      w_sel_nxt = ~(4'b0001 << r_digit);
      w_dig_nxt = {~r_active_ctrl[r_digit], (w_lz_dark ? 7'h7F : w_seg)};
    end
  end

  // Scan FSM keeps running while disabled so re-enabling lands on a frame boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_SHOW;
      r_digit    <= 2'd0;
      r_cnt      <= '0;
      r_disp_sel <= 4'hF;
      r_disp_dig <= 8'hFF;
    end else begin
      r_disp_sel <= w_sel_nxt;
      r_disp_dig <= w_dig_nxt;
      if (w_adv) begin
        r_state <= ST_SHOW;
        r_digit <= r_digit + 2'd1;
        r_cnt   <= '0;
      end else if (w_show_done) begin
        r_state <= ST_BLANK;
        r_cnt   <= '0;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign disp_sel = r_disp_sel;
  assign disp_dig = r_disp_dig;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench: expected lit digits are queued by the stimulus and checked by an independent monitor.
module tb_seg7_scan_ctrl;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  addr  = 2'd0;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic [3:0]  disp_sel;
  logic [7:0]  disp_dig;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int gap   = 0;
  bit mon_en = 1'b1;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] dig;
    int         glo;
    int         ghi;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;

  seg7_scan_ctrl #(
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (2),
    .CNT_W        (17)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .disp_sel (disp_sel),
    .disp_dig (disp_dig)
  );

  always #5 clk = ~clk;

  // Edge counter since reset release: edge n is the n-th rising edge after reset deasserts.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push1(input logic [3:0] s, input logic [7:0] d, input int lo, input int hi, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.sel = s;
      e.dig = d;
      e.glo = (i == 0) ? lo : 0;
      e.ghi = (i == 0) ? hi : 0;
      q.push_back(e);
    end
  endtask

  task automatic push_frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                            input logic [7:0] d3, input int lo, input int hi);
    push1(4'hE, d0, lo, hi, 4);
    push1(4'hD, d1, 2, 2, 4);
    push1(4'hB, d2, 2, 2, 4);
    push1(4'h7, d3, 2, 2, 4);
  endtask

  task automatic wr_at(input int e, input logic [1:0] a, input logic [15:0] d);
    while (cyc < e - 1) @(negedge clk);
    if (cyc != e - 1) begin
      n_vec++;
      n_err++;
      $display("FAIL wr_sched: at edge %0d, needed %0d", cyc, e - 1);
    end
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [15:0] exp, input string name);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  // Monitor: every lit sample (any digit selected) consumes one expectation, including the dark gap before it.
  always @(negedge clk) begin
    if (mon_en) begin
      if (disp_sel == 4'hF) begin
        gap++;
        chk("dark_dig", disp_dig, 8'hFF);
      end else begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_lit: got sel %h dig %h, expected dark", disp_sel, disp_dig);
        end else begin
          e_mon = q.pop_front();
          chk("lit_sel", disp_sel, e_mon.sel);
          chk("lit_dig", disp_dig, e_mon.dig);
          n_vec++;
          if (gap < e_mon.glo || gap > e_mon.ghi) begin
            n_err++;
            $display("FAIL blank_gap: got %0d dark cycles, expected %0d..%0d", gap, e_mon.glo, e_mon.ghi);
          end
        end
        gap = 0;
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sel", disp_sel, 4'hF);
    chk("rst_dig", disp_dig, 8'hFF);
    rd_chk(2'd0, 16'h0000, "rst_value");
    rd_chk(2'd1, 16'h0020, "rst_ctrl");
    push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 0, 1000000);
    @(negedge clk);
    reset = 1'b1;

    // Mid-frame VALUE write: shadow visible at once, display changes next frame
    wr_at(10, 2'd0, 16'h12AF);
    rd_chk(2'd0, 16'h12AF, "value_shadow");
    push_frame(8'h8E, 8'h88, 8'hA4, 8'hF9, 2, 2);

    // Leading-zero suppress, then dp on a suppressed digit
    wr_at(30, 2'd1, 16'h0030);
    wr_at(31, 2'd0, 16'h0005);
    rd_chk(2'd1, 16'h0030, "ctrl_shadow_lz");
    push_frame(8'h92, 8'hFF, 8'hFF, 8'hFF, 2, 2);
    wr_at(50, 2'd1, 16'h0032);
    push_frame(8'h92, 8'h7F, 8'hFF, 8'hFF, 2, 2);

    // Disable for three frames; reserved address writes are dropped
    wr_at(80, 2'd1, 16'h0000);
    wr_at(100, 2'd2, 16'hFFFF);
    rd_chk(2'd2, 16'h0000, "reserved_rd");
    rd_chk(2'd0, 16'h0005, "value_kept");
    rd_chk(2'd1, 16'h0000, "ctrl_off");
    wr_at(150, 2'd1, 16'h0020);
    push_frame(8'h92, 8'hC0, 8'hC0, 8'hC0, 74, 74);

    // Write landing exactly on the commit edge of a pending value
    wr_at(180, 2'd0, 16'h0003);
    push_frame(8'hB0, 8'hC0, 8'hC0, 8'hC0, 2, 2);
    wr_at(192, 2'd0, 16'h0007);
    rd_chk(2'd0, 16'h0007, "value_on_commit");
    push_frame(8'hF8, 8'hC0, 8'hC0, 8'hC0, 2, 2);
    push1(4'hE, 8'hF8, 2, 2, 4);
    push1(4'hD, 8'hC0, 2, 2, 4);
    push1(4'hB, 8'hC0, 2, 2, 1);

    // Asynchronous reset in the middle of SHOW(2)
    wr_at(245, 2'd1, 16'h0031);
    rd_chk(2'd1, 16'h0031, "ctrl_shadow_pre_rst");
    while (cyc < 253) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_sel", disp_sel, 4'hF);
    chk("async_rst_dig", disp_dig, 8'hFF);
    rd_chk(2'd1, 16'h0020, "ctrl_after_rst");
    rd_chk(2'd0, 16'h0000, "value_after_rst");
    chk("queue_before_restart", q.size(), 0);
    repeat (2) @(negedge clk);
    push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 0, 1000000);
    reset = 1'b1;

    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    mon_en = 1'b0;
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
